// File: rtl/fc_infer_scheduler.sv
// fc_infer_scheduler
// Runs the fully-connected classifier one frame at a time and forwards each
// 1-bit class result to the drowsiness warning monitor as an isolated pulse.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_valid   front end has a feature vector ready
//   frame_ready   scheduler can accept a frame (combinational, IDLE only)
//   fc_start      one-cycle start pulse to the FC layer
//   fc_done       FC result valid (single cycle)
//   fc_class      FC result: 0 = drowsy, 1 = awake
//   res_valid     single-cycle result pulse to the warning monitor
//   res_data      result bit, held until the next pulse
//   q_count       result queue occupancy
//   timeout_cnt   saturating count of timed-out frames
//   drop_cnt      saturating count of results dropped on a full queue
//   state         FSM state: 0 IDLE, 1 START, 2 WAIT
module fc_infer_scheduler #(
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned QDEPTH  = 4,
   parameter int unsigned GAP     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      frame_valid,
   output logic                      frame_ready,
   output logic                      fc_start,
   input  logic                      fc_done,
   input  logic                      fc_class,
   output logic                      res_valid,
   output logic                      res_data,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic [7:0]                timeout_cnt,
   output logic [7:0]                drop_cnt,
   output logic [1:0]                state
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = 16;
   localparam int unsigned GW = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t            st;
   logic [WW-1:0]     wait_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [QDEPTH-1:0] mem;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              accept;
   logic              push;
   logic              push_ok;
   logic              pop;
   logic              full;
   logic              empty;

   assign state       = st;
   assign frame_ready = (st == S_IDLE);
   assign accept      = frame_valid && frame_ready;

   // Results only count while waiting; stray done pulses elsewhere are ignored.
   assign push  = (st == S_WAIT) && fc_done;
   assign full  = (q_count == CW'(QDEPTH));
   assign empty = (q_count == '0);

   // Pop only when the output is idle and the inter-pulse gap has elapsed.
   assign pop = !empty && !res_valid && (gap_cnt == '0);

   // A full queue still accepts a push when a pop frees a slot in the same cycle.
   assign push_ok = push && (!full || pop);

   // Frame sequencing FSM with timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= S_IDLE;
         fc_start    <= 1'b0;
         wait_cnt    <= '0;
         timeout_cnt <= '0;
      end else begin
         fc_start <= 1'b0;
         case (st)
            S_IDLE: begin
               if (accept) begin
                  st       <= S_START;
                  fc_start <= 1'b1;
               end
            end
            S_START: begin
               st       <= S_WAIT;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               // done takes priority over a coincident timeout
               if (fc_done) begin
                  st <= S_IDLE;
               end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                  st <= S_IDLE;
                  if (timeout_cnt != 8'hFF) begin
                     timeout_cnt <= timeout_cnt + 8'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   // Queue storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= fc_class;
      end
   end

   // Queue pointers, occupancy, drop counting and paced output.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         q_count   <= '0;
         drop_cnt  <= '0;
         res_valid <= 1'b0;
         res_data  <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         res_valid <= pop;
         if (pop) begin
            res_data <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PW'(1);
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end else if (push && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
         case ({push_ok, pop})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: q_count <= q_count;
         endcase
         // Gap loads on the pulse cycle and counts down while the output is low.
         if (res_valid) begin
            gap_cnt <= GW'(GAP);
         end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fc_infer_scheduler.sv
// Testbench for fc_infer_scheduler. Two instances share all stimulus: one with
// a short output gap (GAP=3) and one with a long gap (GAP=15) so the queue
// fills and drops. Expected result bits go into per-instance scoreboards that
// monitors pop whenever res_valid is seen.
module tb_fc_infer_scheduler;

   localparam int unsigned TO    = 8;
   localparam int unsigned QD    = 4;
   localparam int unsigned GAP_A = 3;
   localparam int unsigned GAP_B = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frame_valid = 1'b0;
   logic fc_done = 1'b0;
   logic fc_class = 1'b0;

   logic       ready_a, start_a, rv_a, rd_a;
   logic [2:0] qc_a;
   logic [7:0] to_a, dr_a;
   logic [1:0] st_a;
   logic       ready_b, start_b, rv_b, rd_b;
   logic [2:0] qc_b;
   logic [7:0] to_b, dr_b;
   logic [1:0] st_b;

   int checks = 0;
   int errors = 0;
   int low_a  = 100;
   int low_b  = 100;
   logic exp_a[$];
   logic exp_b[$];

   always #5 clk = ~clk;

   fc_infer_scheduler #(.TIMEOUT(TO), .QDEPTH(QD), .GAP(GAP_A)) u_a (
      .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(ready_a),
      .fc_start(start_a), .fc_done(fc_done), .fc_class(fc_class),
      .res_valid(rv_a), .res_data(rd_a), .q_count(qc_a),
      .timeout_cnt(to_a), .drop_cnt(dr_a), .state(st_a)
   );

   fc_infer_scheduler #(.TIMEOUT(TO), .QDEPTH(QD), .GAP(GAP_B)) u_b (
      .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(ready_b),
      .fc_start(start_b), .fc_done(fc_done), .fc_class(fc_class),
      .res_valid(rv_b), .res_data(rd_b), .q_count(qc_b),
      .timeout_cnt(to_b), .drop_cnt(dr_b), .state(st_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor for instance A: data order and minimum low gap between pulses.
   always @(negedge clk) begin
      if (rst) begin
         low_a = 100;
      end else if (rv_a === 1'b1) begin
         chk("a_pulse_expected", (exp_a.size() > 0) ? 1 : 0, 1);
         if (exp_a.size() > 0) chk("a_res_data", int'(rd_a), int'(exp_a.pop_front()));
         chk("a_gap_ok", (low_a >= int'(GAP_A)) ? 1 : 0, 1);
         low_a = 0;
      end else begin
         low_a++;
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      if (rst) begin
         low_b = 100;
      end else if (rv_b === 1'b1) begin
         chk("b_pulse_expected", (exp_b.size() > 0) ? 1 : 0, 1);
         if (exp_b.size() > 0) chk("b_res_data", int'(rd_b), int'(exp_b.pop_front()));
         chk("b_gap_ok", (low_b >= int'(GAP_B)) ? 1 : 0, 1);
         low_b = 0;
      end else begin
         low_b++;
      end
   end

   // One frame: accept, start, dly extra WAIT cycles, then done. Called in IDLE.
   task automatic run_frame(input logic cls, input int dly, input bit keep_b);
      chk("frame_ready", int'(ready_a), 1);
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      chk("fc_start", int'(start_a), 1);
      @(negedge clk);
      repeat (dly) @(negedge clk);
      fc_done  = 1'b1;
      fc_class = cls;
      exp_a.push_back(cls);
      if (keep_b) exp_b.push_back(cls);
      @(negedge clk);
      fc_done = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(negedge clk);
      chk("a_drained", exp_a.size(), 0);
      chk("b_drained", exp_b.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_state", int'(st_a), 0);
      chk("rst_fc_start", int'(start_a), 0);
      chk("rst_res_valid", int'(rv_a), 0);
      chk("rst_res_data", int'(rd_a), 0);
      chk("rst_q_count", int'(qc_a), 0);
      chk("rst_timeout_cnt", int'(to_a), 0);
      chk("rst_drop_cnt", int'(dr_a), 0);
      chk("rst_frame_ready", int'(ready_a), 1);
      repeat (2) @(negedge clk);

      // Basic frame: accept N, start N+1, WAIT N+2..N+5, done N+5, pulse N+7
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      chk("t1_start_hi", int'(start_a), 1);
      chk("t1_state_start", int'(st_a), 1);
      chk("t1_ready_lo", int'(ready_a), 0);
      @(negedge clk);
      chk("t1_start_lo", int'(start_a), 0);
      chk("t1_state_wait", int'(st_b), 2);
      repeat (3) @(negedge clk);
      fc_done = 1'b1;
      fc_class = 1'b0;
      exp_a.push_back(1'b0);
      exp_b.push_back(1'b0);
      @(negedge clk);
      fc_done = 1'b0;
      chk("t1_state_idle", int'(st_a), 0);
      chk("t1_rv_not_yet", int'(rv_a), 0);
      @(negedge clk);
      chk("t1_rv_a_m2", int'(rv_a), 1);
      chk("t1_rv_b_m2", int'(rv_b), 1);
      drain(30);

      // Timeout: exactly TO WAIT cycles, counter increments, no result
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      @(negedge clk);
      w = 0;
      while (st_a == 2'd2 && w < 50) begin
         w++;
         @(negedge clk);
      end
      chk("to_wait_cycles", w, int'(TO));
      chk("to_state_idle", int'(st_a), 0);
      chk("to_cnt_a", int'(to_a), 1);
      chk("to_cnt_b", int'(to_b), 1);
      chk("to_ready_back", int'(ready_b), 1);
      repeat (5) @(negedge clk);

      // Done on the last permitted WAIT cycle wins over the timeout
      run_frame(1'b1, int'(TO) - 1, 1'b1);
      chk("last_cycle_to_cnt", int'(to_a), 1);
      chk("last_cycle_q_count", int'(qc_a), 1);

      // Stray done in IDLE is ignored
      drain(40);
      fc_done = 1'b1;
      fc_class = 1'b1;
      @(negedge clk);
      fc_done = 1'b0;
      chk("idle_done_q_a", int'(qc_a), 0);
      chk("idle_done_q_b", int'(qc_b), 0);
      repeat (3) @(negedge clk);

      // Back-to-back frames 0,1,0,0,1,1; B overflows on the last one
      run_frame(1'b0, 0, 1'b1);
      run_frame(1'b1, 0, 1'b1);
      run_frame(1'b0, 0, 1'b1);
      run_frame(1'b0, 0, 1'b1);
      run_frame(1'b1, 0, 1'b1);
      run_frame(1'b1, 0, 1'b0);
      chk("b2b_q_a", int'(qc_a), 3);
      chk("b2b_q_b_full", int'(qc_b), 4);
      chk("b2b_drop_b", int'(dr_b), 1);
      drain(120);
      chk("b2b_drop_a", int'(dr_a), 0);
      chk("b2b_drop_b_final", int'(dr_b), 1);

      // Reset during WAIT with two entries queued in B
      run_frame(1'b1, 0, 1'b1);
      run_frame(1'b0, 0, 1'b1);
      run_frame(1'b1, 0, 1'b1);
      frame_valid = 1'b1;
      @(negedge clk);
      frame_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_state", int'(st_a), 2);
      chk("pre_rst_q_b", int'(qc_b), 2);
      chk("pre_rst_q_a", int'(qc_a), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_state", int'(st_b), 0);
      chk("mid_rst_q_a", int'(qc_a), 0);
      chk("mid_rst_q_b", int'(qc_b), 0);
      chk("mid_rst_rv_b", int'(rv_b), 0);
      chk("mid_rst_to_b", int'(to_b), 0);
      chk("mid_rst_drop_b", int'(dr_b), 0);
      @(negedge clk);
      rst = 1'b0;
      exp_a.delete();
      exp_b.delete();
      fc_done = 1'b1;
      fc_class = 1'b0;
      @(negedge clk);
      fc_done = 1'b0;
      chk("late_done_q_b", int'(qc_b), 0);
      chk("late_done_state", int'(st_a), 0);
      drain(30);

      // Normal operation after reset
      run_frame(1'b0, 2, 1'b1);
      drain(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
